// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - descriptor-in / encoded-word-out handshake bundle for inst_encoder
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage RV32I instruction encoder with illegal-descriptor NOP substitution
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_encoder_if.slave      bus,
    output logic [CNT_W-1:0]   inst_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BRCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_ECBK  = 7'b1110011;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // Stage 1: registered descriptor
    logic        s1_valid_q;
    logic [6:0]  s1_opcode_q;
    logic [2:0]  s1_funct3_q;
    logic        s1_alt_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [31:0] s1_imm_q;

    // Stage 2: registered encoded word
    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic        out_err_q;

    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0] enc_inst_d;
    logic        enc_err_d;
    logic [31:0] raw_inst;
    logic        raw_err;

    logic stall;
    logic s1_advance;
    logic in_fire;
    logic out_fire;

    assign stall      = out_valid_q && !bus.out_ready;
    assign s1_advance = s1_valid_q && !stall;
    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = out_valid_q && bus.out_ready;

    assign bus.in_ready  = !s1_valid_q || s1_advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;
    assign inst_cnt      = inst_cnt_q;
    assign err_cnt       = err_cnt_q;

    // Immediate range checks expressed as "upper bits are a sign extension".
    logic fits12;
    logic fits13;
    logic fits21;

    assign fits12 = (s1_imm_q[31:11] == {21{s1_imm_q[11]}});
    assign fits13 = (s1_imm_q[31:12] == {20{s1_imm_q[12]}});
    assign fits21 = (s1_imm_q[31:20] == {12{s1_imm_q[20]}});

    always_comb begin
        raw_inst = NOP;
        raw_err  = 1'b0;
        case (s1_opcode_q)
            OP_LUI, OP_AUIPC: begin
                raw_inst = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                raw_err  = (s1_imm_q[11:0] != 12'd0);
            end
            OP_JAL: begin
                raw_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, s1_opcode_q};
                raw_err  = s1_imm_q[0] || !fits21;
            end
            OP_BRCH: begin
                raw_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                raw_err  = s1_imm_q[0] || !fits13 ||
                           (s1_funct3_q == 3'b010) || (s1_funct3_q == 3'b011);
            end
            OP_STORE: begin
                raw_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                            s1_opcode_q};
                raw_err  = !fits12 || (s1_funct3_q > 3'b010);
            end
            OP_JALR, OP_FENCE: begin
                raw_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                raw_err  = !fits12 || (s1_funct3_q != 3'b000);
            end
            OP_LOAD: begin
                raw_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                raw_err  = !fits12 || (s1_funct3_q == 3'b011) ||
                           (s1_funct3_q == 3'b110) || (s1_funct3_q == 3'b111);
            end
            OP_ALUI: begin
                // Shifts carry a 5-bit shamt plus funct7; everything else is a plain I-type
                if ((s1_funct3_q == 3'b001) || (s1_funct3_q == 3'b101)) begin
                    raw_inst = {1'b0, s1_alt_q, 5'b00000, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q,
                                s1_rd_q, s1_opcode_q};
                    raw_err  = (s1_imm_q[31:5] != 27'd0) ||
                               (s1_alt_q && (s1_funct3_q == 3'b001));
                end else begin
                    raw_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                    raw_err  = !fits12;
                end
            end
            OP_ALU: begin
                raw_inst = {1'b0, s1_alt_q, 5'b00000, s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_rd_q, s1_opcode_q};
                raw_err  = s1_alt_q && (s1_funct3_q != 3'b000) && (s1_funct3_q != 3'b101);
            end
            OP_ECBK: begin
                raw_inst = {s1_imm_q[11:0], 5'b00000, 3'b000, 5'b00000, s1_opcode_q};
                raw_err  = (s1_imm_q[31:1] != 31'd0);
            end
            default: begin
                raw_inst = NOP;
                raw_err  = 1'b1;
            end
        endcase
    end

    assign enc_err_d  = raw_err;
    assign enc_inst_d = raw_err ? NOP : raw_inst;

    always_comb begin
        inst_cnt_d = inst_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (out_fire) begin
            if (out_err_q) begin
                if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
            end else begin
                if (inst_cnt_q != {CNT_W{1'b1}}) inst_cnt_d = inst_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= 7'd0;
            s1_funct3_q <= 3'd0;
            s1_alt_q    <= 1'b0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_imm_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_err_q   <= 1'b0;
            inst_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q  <= 1'b1;
                s1_opcode_q <= bus.in_opcode;
                s1_funct3_q <= bus.in_funct3;
                s1_alt_q    <= bus.in_alt;
                s1_rd_q     <= bus.in_rd;
                s1_rs1_q    <= bus.in_rs1;
                s1_rs2_q    <= bus.in_rs2;
                s1_imm_q    <= bus.in_imm;
            end else if (s1_advance) begin
                s1_valid_q  <= 1'b0;
            end

            // S2 only changes when not stalled, so a held word stays stable
            if (s1_advance) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= enc_inst_d;
                out_err_q   <= enc_err_d;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            inst_cnt_q <= inst_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - table-driven self-checking bench for inst_encoder
module tb_inst_encoder;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BRCH  = 7'b1100011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALUI  = 7'b0010011;
    localparam logic [6:0] ALU   = 7'b0110011;
    localparam logic [6:0] FENCE = 7'b0001111;
    localparam logic [6:0] ECBK  = 7'b1110011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_encoder_if bus1 ();
    inst_encoder_if bus2 ();
    logic [15:0] inst_cnt1, err_cnt1;
    logic [1:0]  inst_cnt2, err_cnt2;

    inst_encoder #(.CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .inst_cnt(inst_cnt1), .err_cnt(err_cnt1)
    );
    inst_encoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .inst_cnt(inst_cnt2), .err_cnt(err_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vt[26];
    vec_t bp[3];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] e, input logic ee);
        vec_t v;
        v.op = op; v.f3 = f3; v.alt = alt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp_inst = e; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive1(input vec_t v);
        bus1.in_valid = 1'b1; bus1.in_opcode = v.op; bus1.in_funct3 = v.f3; bus1.in_alt = v.alt;
        bus1.in_rd = v.rd; bus1.in_rs1 = v.rs1; bus1.in_rs2 = v.rs2; bus1.in_imm = v.imm;
    endtask

    task automatic drive2(input vec_t v);
        bus2.in_valid = 1'b1; bus2.in_opcode = v.op; bus2.in_funct3 = v.f3; bus2.in_alt = v.alt;
        bus2.in_rd = v.rd; bus2.in_rs1 = v.rs1; bus2.in_rs2 = v.rs2; bus2.in_imm = v.imm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sent, got, n_hs, exp_good, exp_bad;
        logic dropped, stale;

        vt[0]  = mk(ALUI,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0);
        vt[1]  = mk(ALU,   3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0);
        vt[2]  = mk(LUI,   3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        vt[3]  = mk(BRCH,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        vt[4]  = mk(JAL,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3,        32'h00000013, 1'b1);
        vt[5]  = mk(LUI,   3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h00000013, 1'b1);
        vt[6]  = mk(STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0);
        vt[7]  = mk(ALUI,  3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        32'h40315093, 1'b0);
        vt[8]  = mk(ALUI,  3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        32'h00000013, 1'b1);
        vt[9]  = mk(ALUI,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h00000013, 1'b1);
        vt[10] = mk(ALUI,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        vt[11] = mk(ECBK,  3'd5, 1'b0, 5'd7, 5'd3, 5'd0, 32'd1,        32'h00100073, 1'b0);
        vt[12] = mk(ECBK,  3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2,        32'h00000013, 1'b1);
        vt[13] = mk(JAL,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
        vt[14] = mk(JAL,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h00000013, 1'b1);
        vt[15] = mk(BRCH,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00000013, 1'b1);
        vt[16] = mk(LOAD,  3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12283, 1'b0);
        vt[17] = mk(LOAD,  3'd3, 1'b0, 5'd5, 5'd2, 5'd0, 32'd0,        32'h00000013, 1'b1);
        vt[18] = mk(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,        32'h00000013, 1'b1);
        vt[19] = mk(ALU,   3'd1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0,        32'h00000013, 1'b1);
        vt[20] = mk(FENCE, 3'd1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0,        32'h00000013, 1'b1);
        vt[21] = mk(JALR,  3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0,        32'h000280E7, 1'b0);
        vt[22] = mk(BRCH,  3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h00001000, 32'h00000013, 1'b1);
        vt[23] = mk(BRCH,  3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 32'h80000063, 1'b0);
        vt[24] = mk(ALUI,  3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'h00000020, 32'h00000013, 1'b1);
        vt[25] = mk(AUIPC, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h00001000, 32'h00001517, 1'b0);

        bp[0] = mk(ALUI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b0);
        bp[1] = mk(ALUI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1'b0);
        bp[2] = mk(ALUI, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1'b0);

        bus1.in_valid = 1'b0; bus1.in_opcode = '0; bus1.in_funct3 = '0; bus1.in_alt = 1'b0;
        bus1.in_rd = '0; bus1.in_rs1 = '0; bus1.in_rs2 = '0; bus1.in_imm = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_opcode = '0; bus2.in_funct3 = '0; bus2.in_alt = 1'b0;
        bus2.in_rd = '0; bus2.in_rs1 = '0; bus2.in_rs2 = '0; bus2.in_imm = '0; bus2.out_ready = 1'b1;

        // Asynchronous reset takes effect before the first clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", 32'(bus1.out_valid), 32'd0);
        check("reset out_inst",  bus1.out_inst, 32'd0);
        check("reset out_err",   32'(bus1.out_err), 32'd0);
        check("reset in_ready",  32'(bus1.in_ready), 32'd1);
        check("reset inst_cnt",  32'(inst_cnt1), 32'd0);
        check("reset err_cnt",   32'(err_cnt1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_good = 0;
        exp_bad  = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive1(vt[i]);
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(bus1.in_ready), 32'd1);
            @(negedge clk);
            bus1.in_valid = 1'b0;
            lat = 1;
            while (!bus1.out_valid && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d inst", i), bus1.out_inst, vt[i].exp_inst);
            check($sformatf("vec%0d err", i), 32'(bus1.out_err), 32'(vt[i].exp_err));
            if (vt[i].exp_err) exp_bad++;
            else exp_good++;
        end
        @(negedge clk);
        check("table inst_cnt", 32'(inst_cnt1), 32'(exp_good));
        check("table err_cnt",  32'(err_cnt1), 32'(exp_bad));

        // Backpressure: three descriptors while the output is stalled for four cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sent = 0; got = 0; dropped = 1'b0;
        for (int cyc = 1; cyc <= 30 && got < 3; cyc++) begin
            @(negedge clk);
            bus1.out_ready = (cyc > 4);
            if (sent < 3) drive1(bp[sent]);
            else bus1.in_valid = 1'b0;
            #1;
            if (bus1.out_valid && !bus1.out_ready)
                check($sformatf("bp hold cyc%0d", cyc), bus1.out_inst, bp[got].exp_inst);
            if (bus1.out_valid && bus1.out_ready) begin
                check($sformatf("bp out%0d", got), bus1.out_inst, bp[got].exp_inst);
                got++;
            end
            if (sent == 2 && !bus1.out_ready && !bus1.in_ready) dropped = 1'b1;
            if (bus1.in_valid && bus1.in_ready) sent++;
        end
        bus1.in_valid = 1'b0;
        check("bp words out", 32'(got), 32'd3);
        check("bp in_ready dropped", 32'(dropped), 32'd1);
        @(negedge clk);
        check("bp inst_cnt", 32'(inst_cnt1), 32'd3);
        check("bp err_cnt",  32'(err_cnt1), 32'd0);

        // Reset with both stages full clears everything without a clock edge
        bus1.out_ready = 1'b0;
        drive1(bp[0]);
        @(negedge clk);
        drive1(bp[1]);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", 32'(bus1.out_valid), 32'd1);
        check("pre-reset in_ready",  32'(bus1.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus1.out_valid), 32'd0);
        check("midreset out_inst",  bus1.out_inst, 32'd0);
        check("midreset in_ready",  32'(bus1.in_ready), 32'd1);
        check("midreset inst_cnt",  32'(inst_cnt1), 32'd0);
        check("midreset err_cnt",   32'(err_cnt1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        stale = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus1.out_valid) stale = 1'b1;
        end
        check("post-reset no stale word", 32'(stale), 32'd0);
        drive1(bp[2]);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("post-reset first word", bus1.out_inst, bp[2].exp_inst);
        check("post-reset latency", 32'(lat), 32'd2);

        // Saturation of a 2-bit error counter
        n_hs = 0;
        for (int cyc = 0; cyc < 20 && n_hs < 4; cyc++) begin
            @(negedge clk);
            drive2(vt[4]);
            #1;
            if (bus2.in_valid && bus2.in_ready) n_hs++;
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sat handshakes", 32'(n_hs), 32'd4);
        check("sat err_cnt",  32'(err_cnt2), 32'd3);
        check("sat inst_cnt", 32'(inst_cnt2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  request descriptor valid.
REQ-005 SHALL have port in_ready  out  1  encoder accepts the descriptor this cycle.
REQ-006 SHALL have port in_opcode  in  7  opcodeType_e class: LUI, AUIPC, JAL, JALR, BRCH_C, LOAD_C, STORE_C, ALUI_C, ALU_C, FENCE or ECBK_C.
REQ-007 SHALL have port in_funct3  in  3  funct3 field.
REQ-008 SHALL have port in_alt  in  1  alternate-op bit (SUB/SRA/SRAI); it drives funct7[5].
REQ-009 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register addresses (regAddr_t).
REQ-010 SHALL have port in_imm  in  32  signed byte-offset or immediate value, before field splitting.
REQ-011 SHALL have port out_valid  out  1  encoded word valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts out_inst.
REQ-013 SHALL have port out_inst  out  32  encoded instruction_u word.
REQ-014 SHALL have port out_err  out  1  descriptor was illegal; out_inst is a NOP.
REQ-015 SHALL have ports inst_cnt and err_cnt  out  CNT_W each  counts of good and illegal words delivered.

Function
REQ-016 SHALL be a 2-stage valid/ready pipeline: S1 registers the descriptor; S2 registers the encoded word onto out_*.
- Latency: 2 cycles from the input handshake to out_valid.
- Throughput: 1 word per cycle when out_ready=1.
REQ-017 SHALL hold the S2 stall condition as out_valid && !out_ready; while stalled, S2 SHALL hold out_inst and out_err stable.
REQ-018 SHALL advance S1 into S2 when S1 is valid and S2 is not stalled.
REQ-019 SHALL drive in_ready = !s1_valid || s1_advance (combinational), so no descriptor is lost or duplicated under backpressure.
REQ-020 SHALL encode U-type (LUI/AUIPC) as {imm[31:12], rd, opcode}; imm[11:0] != 0 SHALL be an error.
REQ-021 SHALL encode J-type (JAL) as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; an odd imm, or imm outside [-2^20, 2^20-2], SHALL be an error.
REQ-022 SHALL encode B-type as {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode}.
- Error: odd imm.
- Error: imm outside [-4096, 4094].
- Error: funct3 of 010 or 011.
REQ-023 SHALL encode S-type as {imm[11:5], rs2, rs1, f3, imm[4:0], opcode}; imm outside [-2048, 2047], or funct3 not in {SB, SH, SW}, SHALL be an error.
REQ-024 SHALL encode I-type (JALR, LOAD_C, ALUI_C, FENCE) as {imm[11:0], rs1, f3, rd, opcode}.
- Error: imm outside [-2048, 2047].
- JALR and FENCE: error if funct3 != 000.
- LOAD_C: error if funct3 is 011, 110 or 111.
REQ-025 SHALL encode ALUI_C shifts (funct3 001/101) with bits[31:25] = {0, in_alt, 00000} and bits[24:20] = imm[4:0].
- Error: imm[31:5] != 0.
- Error: in_alt=1 with funct3 001.
REQ-026 SHALL encode ALU_C as {0, in_alt, 00000, rs2, rs1, f3, rd, opcode}; in_alt=1 with funct3 not 000/101 SHALL be an error.
REQ-027 SHALL encode ECBK_C with rd=rs1=0 and f3=000 regardless of the inputs; imm SHALL be 0 (ECALL) or 1 (EBREAK), otherwise it is an error.
REQ-028 SHALL treat any other opcode as an error.
REQ-029 SHALL, on any error, output out_inst = 0x00000013 with out_err=1.
REQ-030 SHALL increment inst_cnt on each output handshake with out_err=0 and err_cnt on each handshake with out_err=1; both SHALL saturate at all-ones and never wrap.
REQ-031 SHALL, on simultaneous input and output handshakes, load S1, move S1 to S2 and retire S2 in the same cycle.

Reset
REQ-032 SHALL, while rst_n=0, force immediately (without waiting for a clock edge): s1_valid=0, out_valid=0, out_inst=0, out_err=0, inst_cnt=0, err_cnt=0; in_ready then reads 1.
REQ-033 SHALL discard in-flight descriptors when reset is asserted mid-operation; the first valid output after rst_n rises SHALL come from a post-reset input.

Verification
REQ-034 SHALL cover: ADDI x1,x0,5 (op 0010011, f3 000, imm 5) -> 0x00500093, err=0, two cycles later.
REQ-035 SHALL cover: SUB x3,x1,x2 (ALU_C, alt=1) -> 0x402081B3; then LUI x5, imm 0x12345000 -> 0x123452B7.
REQ-036 SHALL cover: BEQ x1,x2, imm -4 -> 0xFE208EE3; then JAL x1, imm 3 -> 0x00000013, err=1, err_cnt=1.
REQ-037 SHALL cover: stream 3 descriptors with out_ready=0 for 4 cycles -> in_ready drops once 2 are held; all 3 emerge in order; inst_cnt=3.
REQ-038 SHALL cover: rst_n pulled low with both stages valid -> out_valid=0 and counters=0 without a clock edge; no stale word after release.
REQ-039 SHALL cover: preload err_cnt with 2^CNT_W-1 via CNT_W=2 and 4 errors -> err_cnt stays 3.
